bus_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, in parallel with `memory_top`: consumes the same request signals the CPU drives (`o_bus_*`, `o_bhw`, `o_write_notread`) and answers with its own data and DV pulse. Bytes written by software are buffered in a small FIFO and serialised 8N1 on `o_tx` at a software-programmable bit rate. The top level ORs its `o_bus_DV` and `o_bus_data` with those of `memory_top`. Address decode keeps the two devices from responding to the same request.

---
 rtl/bus_uart_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO + 8N1 serialiser with programmable bit rate.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle high, waiting for a FIFO entry
// S_START  | start bit (low) for one bit time
// S_DATA   | 8 data bits, LSB first, indexed by idx_q
// S_PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (high); chains straight into S_START
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_bus_data,
  input  logic [31:0] i_bus_address,
  input  logic        i_bus_DV,
  input  logic [2:0]  i_bhw,
  input  logic        i_write_notread,
  output logic [31:0] o_bus_data,
  output logic        o_bus_DV,
  output logic        o_tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_ON = 1'b1;
`else
  localparam logic PARITY_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // bus decode
  logic       hit;
  logic [1:0] reg_sel;
  logic       wr_txdata;
  logic       rd_status;
  logic       wr_div;

  assign hit       = i_bus_DV && (i_bus_address[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = i_bus_address[3:2];
  assign wr_txdata = hit &&  i_write_notread && (reg_sel == 2'd0);
  assign rd_status = hit && !i_write_notread && (reg_sel == 2'd1);
  assign wr_div    = hit &&  i_write_notread && (reg_sel == 2'd2);

  logic unused_bits;
  assign unused_bits = ^{i_bhw, i_bus_data[31:16], i_bus_address[1:0]};

  // configuration and status registers
  logic [15:0] divisor_q;
  logic        ovf_q;

  // FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             push_ok;
  logic             ovf_set;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // a pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push_ok    = wr_txdata && (!fifo_full || fifo_pop);
  assign ovf_set    = wr_txdata && !push_ok;

  // TX FSM
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] tmr_q, tmr_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        busy;

  assign bit_end = (tmr_q == 16'd0);
  assign busy    = (state_q != S_IDLE);

  // read data
  logic [31:0] status_word;
  logic [31:0] rd_data;

  assign status_word = {16'h0000, 8'(count_q), 3'b000, PARITY_ON,
                        ovf_q | ovf_set, busy, fifo_empty, fifo_full};

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd1:    rd_data = status_word;
      2'd2:    rd_data = {16'h0000, divisor_q};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bus_DV   <= 1'b0;
      o_bus_data <= '0;
    end else begin
      o_bus_DV   <= hit;
      o_bus_data <= (hit && !i_write_notread) ? rd_data : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      divisor_q <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
    end else begin
      if (wr_div) begin
        divisor_q <= i_bus_data[15:0];
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (rd_status) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= i_bus_data[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, fifo_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      tx_q    <= tx_d;
    end
  end

  // divisor is sampled only when a bit starts, so mid-bit writes wait a bit
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tmr_d    = bit_end ? tmr_q : (tmr_q - 16'd1);
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = tmr_q;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_mem[rd_ptr_q];
          tmr_d    = divisor_q;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          tmr_d   = divisor_q;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tmr_d = divisor_q;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tmr_d   = divisor_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_mem[rd_ptr_q];
            tmr_d    = divisor_q;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // line level registered from the next state so o_tx is glitch-free
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[idx_d];
      S_PARITY: tx_d = ^shift_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign o_tx = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed register checks plus random
// byte bursts compared against a bit-level model of the expected serial line.
module tb_bus_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int          NB    = 10 + PAR;
  localparam logic [31:0] PBIT  = (PAR != 0) ? 32'h10 : 32'h0;
  localparam logic [31:0] ST_IDLE = 32'h2 | PBIT;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_bus_data = '0;
  logic [31:0] i_bus_address = '0;
  logic        i_bus_DV = 1'b0;
  logic [2:0]  i_bhw = 3'd2;
  logic        i_write_notread = 1'b0;
  logic [31:0] o_bus_data;
  logic        o_bus_DV;
  logic        o_tx;

  bus_uart_tx dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_bus_data      (i_bus_data),
    .i_bus_address   (i_bus_address),
    .i_bus_DV        (i_bus_DV),
    .i_bhw           (i_bhw),
    .i_write_notread (i_write_notread),
    .o_bus_data      (o_bus_data),
    .o_bus_DV        (o_bus_DV),
    .o_tx            (o_tx)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic       exp_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] burst_q[$];
  int         occ;
  int         dropped;
  logic       started;

  always @(posedge i_clk) begin
    #2;
    if (cap_en) cap_q.push_back(o_tx);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic dv, output logic [31:0] rdata);
    i_bus_DV        = 1'b1;
    i_write_notread = we;
    i_bus_address   = addr;
    i_bus_data      = wdata;
    i_bhw           = 3'($urandom_range(0, 7));
    @(posedge i_clk); #1;
    dv    = o_bus_DV;
    rdata = o_bus_data;
    i_bus_DV        = 1'b0;
    i_write_notread = 1'b0;
    i_bus_address   = '0;
    i_bus_data      = '0;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    logic dv;
    logic [31:0] rd;
    do_req(1'b1, addr, wdata, dv, rd);
    check({tag, "_dv"}, 32'(dv), 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic dv;
    logic [31:0] rd;
    do_req(1'b0, addr, 32'h0, dv, rd);
    check({tag, "_dv"}, 32'(dv), 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic miss_check(input string tag, input logic we, input logic [31:0] addr);
    logic dv;
    logic [31:0] rd;
    do_req(we, addr, 32'hDEAD_BEEF, dv, rd);
    check({tag, "_dv"}, 32'(dv), 32'd0);
    check({tag, "_data"}, rd, 32'd0);
  endtask

  // Model: at the edge sampling each write, an idle transmitter first pops
  // a waiting byte, then the write is accepted if a slot is free.
  task automatic burst();
    occ = 0; dropped = 0; started = 1'b0;
    sent_q.delete();
    foreach (burst_q[k]) begin
      if (!started && occ > 0) begin
        occ--;
        started = 1'b1;
      end
      if (occ < DEPTH) begin
        occ++;
        sent_q.push_back(burst_q[k]);
      end else begin
        dropped++;
      end
      wr("txdata", BASE, {24'h0, burst_q[k]});
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR != 0 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // two idle samples, then contiguous frames starting at the pop edge
  task automatic build_exp(input int div, input int tail);
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    foreach (sent_q[j])
      for (int k = 0; k < NB; k++)
        for (int c = 0; c <= div; c++)
          exp_q.push_back(frame_bit(sent_q[j], k));
    for (int t = 0; t < tail; t++) exp_q.push_back(1'b1);
  endtask

  task automatic start_cap();
    cap_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic finish_cap(input string tag);
    int errs = 0;
    int guard = 0;
    while (cap_q.size() < exp_q.size() + 1 && guard < 40000) begin
      @(posedge i_clk);
      guard++;
    end
    #1;
    cap_en = 1'b0;
    check({tag, "_len"}, 32'(cap_q.size() >= exp_q.size()), 32'd1);
    foreach (exp_q[i])
      if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) errs++;
    check({tag, "_bad_samples"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int div;
    int n;
    logic [31:0] ovf_word;

    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_dv", 32'(o_bus_DV), 32'd0);
    check("rst_data", o_bus_data, 32'd0);

    rd_check("rst_status", BASE + 32'd4, ST_IDLE);
    rd_check("rst_div", BASE + 32'd8, 32'd433);
    @(posedge i_clk); #1;
    check("dv_one_cycle", 32'(o_bus_DV), 32'd0);
    check("data_zero_idle", o_bus_data, 32'd0);
    check("idle_tx", 32'(o_tx), 32'd1);

    rd_check("txdata_read", BASE, 32'd0);
    wr("reg3_wr", BASE + 32'd12, 32'h1234_5678);
    rd_check("reg3_read", BASE + 32'd12, 32'd0);
    rd_check("div_after_reg3", BASE + 32'd8, 32'd433);

    miss_check("miss_hi", 1'b0, BASE + 32'h10);
    miss_check("miss_lo", 1'b0, BASE - 32'd4);
    miss_check("miss_wr", 1'b1, BASE - 32'd4);
    rd_check("div_after_miss", BASE + 32'd8, 32'd433);

    wr("div3", BASE + 32'd8, 32'hABCD_0003);
    rd_check("div3_read", BASE + 32'd8, 32'd3);
    start_cap();
    burst_q = '{8'h55};
    burst();
    build_exp(3, 8);
    finish_cap("frame_55");
    check("tx_fall_edge", 32'(cap_q[2]), 32'd0);
    rd_check("status_after_55", BASE + 32'd4, ST_IDLE);

    wr("div0", BASE + 32'd8, 32'd0);
    start_cap();
    burst_q = '{8'h41, 8'h42, 8'h43};
    burst();
    build_exp(0, 6);
    finish_cap("b2b_frames");
    rd_check("status_after_b2b", BASE + 32'd4, ST_IDLE);

    for (int r = 0; r < 3; r++) begin
      div = $urandom_range(0, 3);
      n   = $urandom_range(1, 5);
      wr("rand_div", BASE + 32'd8, 32'(div));
      burst_q.delete();
      for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
      start_cap();
      burst();
      build_exp(div, 6);
      finish_cap("rand_stream");
      rd_check("rand_status", BASE + 32'd4, ST_IDLE);
    end

    wr("div100", BASE + 32'd8, 32'd100);
    burst_q.delete();
    for (int i = 0; i < 10; i++) burst_q.push_back(8'($urandom));
    start_cap();
    burst();
    ovf_word = (32'(occ) << 8) | ((dropped > 0) ? 32'h8 : 32'h0) | 32'h4
             | ((occ == DEPTH) ? 32'h1 : 32'h0) | PBIT;
    rd_check("ovf_status", BASE + 32'd4, ovf_word);
    rd_check("ovf_cleared", BASE + 32'd4, ovf_word & ~32'h8);
    build_exp(100, 4);
    finish_cap("ovf_stream");
    rd_check("status_after_drain", BASE + 32'd4, ST_IDLE);

    wr("div3_again", BASE + 32'd8, 32'd3);
    burst_q = '{8'hF0, 8'h0F};
    burst();
    check("pre_rst_low", 32'(o_tx), 32'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("mid_rst_tx", 32'(o_tx), 32'd1);
    i_rst = 1'b0;
    rd_check("post_rst_status", BASE + 32'd4, ST_IDLE);
    rd_check("post_rst_div", BASE + 32'd8, 32'd433);
    sent_q.delete();
    start_cap();
    build_exp(0, 60);
    finish_cap("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
